// File: rtl/fpu_move_ctrl_pkg.sv
// Shared FPU move-control definitions: FSM state encoding and move opcodes.
package fpu_move_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } mv_state_e;

  localparam logic [1:0] MV_NOP = 2'b00;
  localparam logic [1:0] MV_I2F = 2'b01;
  localparam logic [1:0] MV_F2I = 2'b10;

  // Origin 0 is the integer-to-FP channel, origin 1 the FP-to-integer channel.
  function automatic logic [1:0] origin_opcode(input logic origin);
    return origin ? MV_F2I : MV_I2F;
  endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-requester round-robin arbiter; 'last' names the requester granted most recently.
module fpu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fpu_move_ctrl.sv
// Sequences int<->FP register moves through an external move datapath and
// returns the result on a registered write-back handshake.
module fpu_move_ctrl
  import fpu_move_ctrl_pkg::*;
#(
  parameter int Std = 31
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [Std:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [Std:0] req1_data,
  output logic [1:0]   mv_opcode,
  output logic [Std:0] mv_data,
  input  logic [Std:0] mv_result,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [Std:0] wb_data,
  output logic         wb_dest,
  output logic         busy
);

  mv_state_e    r_state;
  mv_state_e    w_state_next;
  logic         r_last_grant;
  logic [Std:0] r_operand;
  logic [1:0]   r_opcode;
  logic         r_dest;
  logic [Std:0] r_wb_data;
  logic [15:0]  r_cnt0;
  logic [15:0]  r_cnt1;

  logic [1:0]   w_gnt;
  logic         w_arb_en;
  logic         w_accept;
  logic         w_sel;

  // Gating with rst_l keeps both readies low for the whole reset assertion.
  assign w_arb_en = (r_state == IDLE) && rst_l;
  assign w_accept = |w_gnt;
  assign w_sel    = w_gnt[1];

  fpu_rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (r_last_grant),
    .en   (w_arb_en),
    .gnt  (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req0_ready   = w_gnt[0];
    req1_ready   = w_gnt[1];
    mv_opcode    = MV_NOP;
    mv_data      = '0;
    wb_valid     = 1'b0;
    busy         = (r_state != IDLE);
    wb_data      = r_wb_data;
    wb_dest      = r_dest;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        mv_opcode    = r_opcode;
        mv_data      = r_operand;
        w_state_next = RESP;
      end
      RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_last_grant <= 1'b1;
      r_operand    <= '0;
      r_opcode     <= MV_NOP;
      r_dest       <= 1'b0;
      r_wb_data    <= '0;
    end else begin
      if (w_accept) begin
        r_operand    <= w_sel ? req1_data : req0_data;
        r_opcode     <= origin_opcode(w_sel);
        r_dest       <= w_sel;
        r_last_grant <= w_sel;
      end
      if (r_state == EXEC) begin
        r_wb_data <= mv_result;
      end
    end
  end

  // Per-channel acceptance counters, visible only through the hierarchy.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt0 <= 16'h0000;
      r_cnt1 <= 16'h0000;
    end else begin
      if (w_gnt[0]) begin
        r_cnt0 <= r_cnt0 + 16'd1;
      end
      if (w_gnt[1]) begin
        r_cnt1 <= r_cnt1 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_move_ctrl.sv
// Self-checking bench for fpu_move_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_fpu_move_ctrl;

  localparam int Std = 31;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic [Std:0] req0_data = '0;
  logic [Std:0] req1_data = '0;
  logic         req0_ready, req1_ready;
  logic [1:0]   mv_opcode;
  logic [Std:0] mv_data;
  logic [Std:0] mv_result;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [Std:0] wb_data;
  logic         wb_dest;
  logic         busy;

  // Move datapath stand-in: XOR with a key (key = 0 mirrors the operand).
  logic [Std:0] key = '0;
  assign mv_result = mv_data ^ key;

  always #5 clk = ~clk;

  fpu_move_ctrl #(.Std(Std)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .mv_opcode  (mv_opcode),
    .mv_data    (mv_data),
    .mv_result  (mv_result),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_dest    (wb_dest),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase of the single in-flight move (0 none, 1 in datapath,
  // 2 awaiting write-back), plus the fairness pointer and counters.
  int           m_phase;
  int           m_last;
  logic [Std:0] m_opd;
  logic [Std:0] m_wbd;
  logic         m_dest;
  logic [15:0]  m_cnt0;
  logic [15:0]  m_cnt1;
  bit           hold_valid = 1'b0;
  logic         q_dest[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1;
    m_opd   = '0;
    m_wbd   = '0;
    m_dest  = 1'b0;
    m_cnt0  = 16'h0;
    m_cnt1  = 16'h0;
  endtask

  // Called at a falling edge with inputs already driven; checks, predicts, advances one cycle.
  task automatic tick();
    int g;
    logic [1:0] exp_op;
    #1;
    g = (m_phase == 0) ? pick() : -1;
    exp_op = (m_phase == 1) ? (m_dest ? 2'b10 : 2'b01) : 2'b00;
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("busy", busy, m_phase != 0);
    chk("wb_valid", wb_valid, m_phase == 2);
    chk("wb_data", wb_data, m_wbd);
    chk("wb_dest", wb_dest, m_dest);
    chk("mv_opcode", mv_opcode, exp_op);
    chk("mv_data", mv_data, (m_phase == 1) ? m_opd : '0);
    chk("cnt0", dut.r_cnt0, m_cnt0);
    chk("cnt1", dut.r_cnt1, m_cnt1);
    $display("cycle t=%0t v=%b%b rdy=%b%b op=%0d wb_v=%b wb_r=%b wb_data=%h dest=%b",
             $time, req1_valid, req0_valid, req1_ready, req0_ready, mv_opcode,
             wb_valid, wb_ready, wb_data, wb_dest);
    if (wb_valid && wb_ready) q_dest.push_back(wb_dest);
    case (m_phase)
      0: if (g >= 0) begin
        m_opd  = (g == 1) ? req1_data : req0_data;
        m_dest = (g == 1);
        m_last = g;
        if (g == 0) m_cnt0 = m_cnt0 + 16'd1;
        else        m_cnt1 = m_cnt1 + 16'd1;
        m_phase = 1;
      end
      1: begin
        m_wbd   = m_opd ^ key;
        m_phase = 2;
      end
      default: if (wb_ready) m_phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
    if (g >= 0 && !hold_valid) begin
      if (g == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
    end
  endtask

  // Drops rst_l wherever we are and checks the outputs clear without a clock edge.
  task automatic async_reset_check(input string tag);
    rst_l = 1'b0;
    #1;
    chk({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_wb_data"}, wb_data, '0);
    chk({tag, "_wb_dest"}, wb_dest, 1'b0);
    chk({tag, "_mv_opcode"}, mv_opcode, 2'b00);
    chk({tag, "_mv_data"}, mv_data, '0);
    chk({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk({tag, "_cnt0"}, dut.r_cnt0, 16'h0);
    chk({tag, "_cnt1"}, dut.r_cnt1, 16'h0);
    model_reset();
  endtask

  initial begin
    logic [Std:0] saved;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset: requesters valid must still see ready low.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    async_reset_check("reset");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;

    // Single integer-to-FP move through a mirroring datapath.
    key = '0;
    wb_ready = 1'b1;
    req0_data = 32'h3F80_0000;
    req0_valid = 1'b1;
    repeat (4) tick();
    chk("i2f_wb_data", wb_data, 32'h3F80_0000);

    // Contention from reset with both requesters held valid.
    async_reset_check("rst2");
    @(negedge clk);
    rst_l = 1'b1;
    hold_valid = 1'b1;
    req0_data = 32'h1111_1111;
    req1_data = 32'h2222_2222;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    q_dest.delete();
    repeat (12) tick();
    hold_valid = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_count", q_dest.size(), 4);
    for (int i = 0; i < 4 && i < q_dest.size(); i++)
      chk($sformatf("rr_dest%0d", i), q_dest[i], i % 2);
    chk("rr_cnt0", dut.r_cnt0, 16'd2);
    chk("rr_cnt1", dut.r_cnt1, 16'd2);

    // Back-pressure: five cycles of wb_ready low while a competitor waits.
    wb_ready = 1'b0;
    req1_data = $urandom;
    req1_valid = 1'b1;
    repeat (2) tick();
    saved = wb_data;
    req0_data = $urandom;
    req0_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_wb_data_stable", wb_data, saved);
    end
    wb_ready = 1'b1;
    repeat (5) tick();

    // Reset in the middle of a write-back, then a pending req1 on release.
    wb_ready = 1'b0;
    req0_data = $urandom;
    req0_valid = 1'b1;
    repeat (2) tick();
    chk("pre_rst_wb_valid", wb_valid, 1'b1);
    #2;
    async_reset_check("midresp");
    req0_valid = 1'b0;
    req1_data = $urandom;
    req1_valid = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    chk("post_rst_op", mv_opcode, 2'b10);
    wb_ready = 1'b1;
    repeat (3) tick();

    // Counter wrap on req1.
    saved = {16'h0, dut.r_cnt0};
    force dut.r_cnt1 = 16'hFFFF;
    #1;
    release dut.r_cnt1;
    m_cnt1 = 16'hFFFF;
    req1_data = $urandom;
    req1_valid = 1'b1;
    repeat (4) tick();
    chk("wrap_cnt1", dut.r_cnt1, 16'h0000);
    chk("wrap_cnt0", dut.r_cnt0, saved[15:0]);

    // Random traffic with random back-pressure.
    key = $urandom;
    repeat (300) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1;
        req0_data = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1;
        req1_data = $urandom;
      end
      wb_ready = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
